// File: rtl/roi_polygon_mask_stream_if.sv
// AXI4-Stream video beat bundle used for both the input and output side of the ROI masker.
interface roi_polygon_mask_stream_if #(
  parameter int DATA_W = 24
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic              tuser;

  modport master (output tdata, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/roi_polygon_mask_stream.sv
// Convex-polygon ROI masker for an AXI4-Stream video feed: 3-stage pipeline with full
// backpressure, double-buffered polygon/mode/fill, per-frame inside count and line-length check.
module roi_polygon_mask_stream #(
  parameter int DATA_W       = 24,
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter int NUM_VERTS    = 4,
  parameter int COORD_W      = 12,
  localparam int CNT_W       = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT + 1)
) (
  input  logic                      aclk,
  input  logic                      areset,
  roi_polygon_mask_stream_if.slave  s_axis,
  roi_polygon_mask_stream_if.master m_axis,
  input  logic                      cfg_wr,
  input  logic [2:0]                cfg_idx,
  input  logic [COORD_W-1:0]        cfg_x,
  input  logic [COORD_W-1:0]        cfg_y,
  input  logic [1:0]                cfg_mode,
  input  logic [DATA_W-1:0]         cfg_fill,
  input  logic                      cfg_commit,
  output logic                      cfg_pending,
  output logic [CNT_W-1:0]          frame_inside_count,
  output logic                      frame_stat_valid,
  output logic                      line_err
);

  typedef enum logic [1:0] {
    MODE_PASS     = 2'd0,
    MODE_ZERO_OUT = 2'd1,
    MODE_ZERO_IN  = 2'd2,
    MODE_FILL     = 2'd3
  } mode_e;

  localparam int SW = COORD_W + 1;
  localparam int PW = 2 * COORD_W + 3;
  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(IMAGE_WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(IMAGE_HEIGHT - 1);

  logic ce, s_fire, m_fire, keep, load_active;

  assign ce            = m_axis.tready | ~m_axis.tvalid;
  assign s_axis.tready = ce;
  assign s_fire        = s_axis.tvalid & ce;
  assign m_fire        = m_axis.tvalid & m_axis.tready;

  // Coordinate tracking; "synced" drops beats after reset until a start of frame arrives.
  logic [COORD_W-1:0] x_cnt, y_cnt, cur_x, cur_y;
  logic               synced;

  assign cur_x = s_axis.tuser ? '0 : x_cnt;
  assign cur_y = s_axis.tuser ? '0 : y_cnt;
  assign keep  = synced | s_axis.tuser;

  // NOTE: every clocked block uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      x_cnt    <= '0;
      y_cnt    <= '0;
      synced   <= 1'b0;
      line_err <= 1'b0;
    end else begin
      if (s_fire) begin
        if (s_axis.tuser) begin
          x_cnt  <= COORD_W'(1);
          y_cnt  <= '0;
          synced <= 1'b1;
        end else if (s_axis.tlast) begin
          x_cnt <= '0;
          if (y_cnt != Y_MAX) y_cnt <= y_cnt + COORD_W'(1);
        end else if (x_cnt != X_MAX) begin
          x_cnt <= x_cnt + COORD_W'(1);
        end
      end
      if (cfg_commit)
        line_err <= 1'b0;
      else if (s_fire && keep && (s_axis.tlast ? (cur_x != X_MAX) : (cur_x == X_MAX)))
        line_err <= 1'b1;
    end
  end

  logic [COORD_W-1:0] sh_x  [NUM_VERTS];
  logic [COORD_W-1:0] sh_y  [NUM_VERTS];
  logic [COORD_W-1:0] act_x [NUM_VERTS];
  logic [COORD_W-1:0] act_y [NUM_VERTS];
  mode_e              sh_mode, act_mode;
  logic [DATA_W-1:0]  sh_fill, act_fill;

  assign load_active = s_fire & s_axis.tuser & cfg_pending;

  // NOTE: the vertex banks are a few flops each, not RAM, so they take the async reset like any register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < NUM_VERTS; i++) begin
        sh_x[i]  <= '0;
        sh_y[i]  <= '0;
        act_x[i] <= '0;
        act_y[i] <= '0;
      end
      sh_mode     <= MODE_PASS;
      act_mode    <= MODE_PASS;
      sh_fill     <= '0;
      act_fill    <= '0;
      cfg_pending <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_VERTS; i++) begin
        if (cfg_wr && cfg_idx == 3'(i)) begin
          sh_x[i] <= cfg_x;
          sh_y[i] <= cfg_y;
        end
      end
      if (cfg_commit) begin
        sh_mode <= mode_e'(cfg_mode);
        sh_fill <= cfg_fill;
      end
      // Shadow is sampled before this edge's cfg_wr/cfg_commit land, so those go to the next frame.
      if (load_active) begin
        for (int i = 0; i < NUM_VERTS; i++) begin
          act_x[i] <= sh_x[i];
          act_y[i] <= sh_y[i];
        end
        act_mode <= sh_mode;
        act_fill <= sh_fill;
      end
      if (cfg_commit)       cfg_pending <= 1'b1;
      else if (load_active) cfg_pending <= 1'b0;
    end
  end

  // S0: capture beat and its coordinates.
  logic               s0_valid, s0_last, s0_user;
  logic [DATA_W-1:0]  s0_data;
  logic [COORD_W-1:0] s0_x, s0_y;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      s0_valid <= 1'b0;
      s0_last  <= 1'b0;
      s0_user  <= 1'b0;
      s0_data  <= '0;
      s0_x     <= '0;
      s0_y     <= '0;
    end else if (ce) begin
      s0_valid <= s_fire & keep;
      s0_last  <= s_axis.tlast;
      s0_user  <= s_axis.tuser;
      s0_data  <= s_axis.tdata;
      s0_x     <= cur_x;
      s0_y     <= cur_y;
    end
  end

  // S1: edge vectors and pixel offsets against the active polygon.
  logic signed [SW-1:0] dx_c [NUM_VERTS];
  logic signed [SW-1:0] dy_c [NUM_VERTS];
  logic signed [SW-1:0] px_c [NUM_VERTS];
  logic signed [SW-1:0] py_c [NUM_VERTS];

  always_comb begin
    for (int i = 0; i < NUM_VERTS; i++) begin
      dx_c[i] = $signed({1'b0, act_x[(i + 1) % NUM_VERTS]}) - $signed({1'b0, act_x[i]});
      dy_c[i] = $signed({1'b0, act_y[(i + 1) % NUM_VERTS]}) - $signed({1'b0, act_y[i]});
      px_c[i] = $signed({1'b0, s0_x}) - $signed({1'b0, act_x[i]});
      py_c[i] = $signed({1'b0, s0_y}) - $signed({1'b0, act_y[i]});
    end
  end

  logic signed [SW-1:0] s1_dx [NUM_VERTS];
  logic signed [SW-1:0] s1_dy [NUM_VERTS];
  logic signed [SW-1:0] s1_px [NUM_VERTS];
  logic signed [SW-1:0] s1_py [NUM_VERTS];
  logic                 s1_valid, s1_last, s1_user;
  logic [DATA_W-1:0]    s1_data, s1_fill;
  mode_e                s1_mode;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < NUM_VERTS; i++) begin
        s1_dx[i] <= '0;
        s1_dy[i] <= '0;
        s1_px[i] <= '0;
        s1_py[i] <= '0;
      end
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_user  <= 1'b0;
      s1_data  <= '0;
      s1_fill  <= '0;
      s1_mode  <= MODE_PASS;
    end else if (ce) begin
      for (int i = 0; i < NUM_VERTS; i++) begin
        s1_dx[i] <= dx_c[i];
        s1_dy[i] <= dy_c[i];
        s1_px[i] <= px_c[i];
        s1_py[i] <= py_c[i];
      end
      s1_valid <= s0_valid;
      s1_last  <= s0_last;
      s1_user  <= s0_user;
      s1_data  <= s0_data;
      s1_fill  <= act_fill;
      s1_mode  <= act_mode;
    end
  end

  // S2: cross products, inside decision (boundary counts as inside) and mode mux.
  logic signed [PW-1:0] side_c [NUM_VERTS];
  logic                 inside_c;
  logic [DATA_W-1:0]    out_c;

  always_comb begin
    // NOTE: defaults first so no path through this block can leave a variable unassigned (no latches).
    inside_c = 1'b1;
    out_c    = s1_data;
    for (int i = 0; i < NUM_VERTS; i++) begin
      side_c[i] = PW'(s1_dx[i]) * PW'(s1_py[i]) - PW'(s1_dy[i]) * PW'(s1_px[i]);
      if (!side_c[i][PW-1] && (side_c[i] != '0)) inside_c = 1'b0;
    end
    case (s1_mode)
      MODE_PASS:     out_c = s1_data;
      MODE_ZERO_OUT: out_c = inside_c ? s1_data : '0;
      MODE_ZERO_IN:  out_c = inside_c ? '0 : s1_data;
      MODE_FILL:     out_c = inside_c ? s1_data : s1_fill;
    endcase
  end

  logic              s2_valid, s2_last, s2_user, s2_inside;
  logic [DATA_W-1:0] s2_data;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      s2_valid  <= 1'b0;
      s2_last   <= 1'b0;
      s2_user   <= 1'b0;
      s2_inside <= 1'b0;
      s2_data   <= '0;
    end else if (ce) begin
      s2_valid  <= s1_valid;
      s2_last   <= s1_last;
      s2_user   <= s1_user;
      s2_inside <= inside_c;
      s2_data   <= out_c;
    end
  end

  assign m_axis.tvalid = s2_valid;
  assign m_axis.tdata  = s2_data;
  assign m_axis.tlast  = s2_last;
  assign m_axis.tuser  = s2_user;

  // Frame statistics are taken at the output so they follow the beats actually delivered.
  logic [CNT_W-1:0] inside_acc;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      inside_acc         <= '0;
      frame_inside_count <= '0;
      frame_stat_valid   <= 1'b0;
    end else begin
      frame_stat_valid <= 1'b0;
      if (m_fire) begin
        if (s2_user) begin
          frame_inside_count <= inside_acc;
          frame_stat_valid   <= 1'b1;
          inside_acc         <= CNT_W'(s2_inside);
        end else begin
          inside_acc <= inside_acc + CNT_W'(s2_inside);
        end
      end
    end
  end

endmodule

// File: tb/tb_roi_polygon_mask_stream.sv
// Scoreboard bench for roi_polygon_mask_stream on a reduced 32x24 frame.
module tb_roi_polygon_mask_stream;

  localparam int DW    = 24;
  localparam int W     = 32;
  localparam int H     = 24;
  localparam int NV    = 4;
  localparam int CW    = 12;
  localparam int CNT_W = $clog2(W * H + 1);
  localparam int FRAME = W * H;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic          user;
  } beat_t;

  logic           aclk = 1'b0;
  logic           areset = 1'b1;
  logic           cfg_wr = 1'b0;
  logic           cfg_commit = 1'b0;
  logic [2:0]     cfg_idx = '0;
  logic [CW-1:0]  cfg_x = '0;
  logic [CW-1:0]  cfg_y = '0;
  logic [1:0]     cfg_mode = '0;
  logic [DW-1:0]  cfg_fill = '0;
  logic           cfg_pending, frame_stat_valid, line_err;
  logic [CNT_W-1:0] frame_inside_count;

  roi_polygon_mask_stream_if #(.DATA_W(DW)) s_if ();
  roi_polygon_mask_stream_if #(.DATA_W(DW)) m_if ();

  roi_polygon_mask_stream #(
    .DATA_W(DW), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .NUM_VERTS(NV), .COORD_W(CW)
  ) dut (
    .aclk(aclk), .areset(areset), .s_axis(s_if), .m_axis(m_if),
    .cfg_wr(cfg_wr), .cfg_idx(cfg_idx), .cfg_x(cfg_x), .cfg_y(cfg_y),
    .cfg_mode(cfg_mode), .cfg_fill(cfg_fill), .cfg_commit(cfg_commit),
    .cfg_pending(cfg_pending), .frame_inside_count(frame_inside_count),
    .frame_stat_valid(frame_stat_valid), .line_err(line_err)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail   = 0;

  beat_t         exp_q[$];
  int            stat_q[$];
  logic [DW-1:0] out_log[$];
  int            stat_log[$];

  // Reference configuration model: shadow and active sets with frame-start hand-over.
  int            s_vx[NV], s_vy[NV], a_vx[NV], a_vy[NV];
  int            s_mode, a_mode, m_acc;
  logic [DW-1:0] s_fill, a_fill;
  bit            m_pending;
  bit            rand_rdy = 1'b0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_bound(string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  function automatic logic [DW-1:0] pix(int x, int y);
    return {8'h80, 8'(y), 8'(x)};
  endfunction

  function automatic bit inside_f(int x, int y);
    bit in = 1'b1;
    for (int i = 0; i < NV; i++) begin
      int n = (i + 1) % NV;
      int side = (a_vx[n] - a_vx[i]) * (y - a_vy[i]) - (a_vy[n] - a_vy[i]) * (x - a_vx[i]);
      if (side > 0) in = 1'b0;
    end
    return in;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      s_vx[i] = 0; s_vy[i] = 0; a_vx[i] = 0; a_vy[i] = 0;
    end
    s_mode = 0; a_mode = 0; s_fill = '0; a_fill = '0;
    m_pending = 1'b0; m_acc = 0;
  endtask

  task automatic send_beat(int x, int y, bit last, bit user, bit track);
    bit ok;
    int guard = 0;
    beat_t e;
    bit in;
    s_if.tdata  = pix(x, y);
    s_if.tlast  = last;
    s_if.tuser  = user;
    s_if.tvalid = 1'b1;
    forever begin
      @(negedge aclk);
      ok = s_if.tready;
      @(posedge aclk);
      #1;
      if (ok) break;
      guard++;
      if (guard > 1000) begin
        fail_bound("input_accept");
        break;
      end
    end
    if (track) begin
      if (user) begin
        stat_q.push_back(m_acc);
        if (m_pending) begin
          for (int i = 0; i < NV; i++) begin
            a_vx[i] = s_vx[i]; a_vy[i] = s_vy[i];
          end
          a_mode = s_mode; a_fill = s_fill; m_pending = 1'b0;
        end
      end
      in    = inside_f(x, y);
      m_acc = user ? int'(in) : m_acc + int'(in);
      e.last = last;
      e.user = user;
      case (a_mode)
        1:       e.data = in ? pix(x, y) : '0;
        2:       e.data = in ? '0 : pix(x, y);
        3:       e.data = in ? pix(x, y) : a_fill;
        default: e.data = pix(x, y);
      endcase
      exp_q.push_back(e);
    end
  endtask

  task automatic cfg_write(int idx, int x, int y);
    cfg_wr = 1'b1; cfg_idx = 3'(idx); cfg_x = CW'(x); cfg_y = CW'(y);
    @(posedge aclk); #1;
    cfg_wr = 1'b0;
    s_vx[idx] = x; s_vy[idx] = y;
  endtask

  task automatic do_commit(int mode, logic [DW-1:0] fill);
    cfg_commit = 1'b1; cfg_mode = 2'(mode); cfg_fill = fill;
    @(posedge aclk); #1;
    cfg_commit = 1'b0;
    s_mode = mode; s_fill = fill; m_pending = 1'b1;
  endtask

  // hook 1: load the triangle in fill mode mid-frame; hook 2: commit zero-inside mode.
  task automatic send_frame(int short_line, int hook, bit chk_pend);
    for (int y = 0; y < H; y++) begin
      int len = (y == short_line) ? W - 1 : W;
      for (int x = 0; x < len; x++) begin
        if (hook != 0 && y == 5 && x == 0) begin
          s_if.tvalid = 1'b0;
          if (hook == 1) begin
            cfg_write(0, 0, 0);
            cfg_write(1, 0, 23);
            cfg_write(2, 31, 23);
            cfg_write(3, 0, 0);
            do_commit(3, 24'hFF00FF);
            check("pending_after_midframe_commit", cfg_pending, 1);
          end else begin
            do_commit(2, 24'hFF00FF);
          end
        end
        send_beat(x, y, x == len - 1, x == 0 && y == 0, 1'b1);
        if (chk_pend && x == 0 && y == 0) check("pending_cleared_at_sof", cfg_pending, 0);
      end
    end
    s_if.tvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((exp_q.size() != 0 || stat_q.size() != 0) && g < 5000) begin
      @(posedge aclk);
      g++;
    end
    repeat (4) @(posedge aclk);
    #1;
    if (g >= 5000) fail_bound("drain");
  endtask

  task automatic chk_px(string name, int frame, int x, int y, logic [DW-1:0] e);
    int idx = frame * FRAME + y * W + x;
    if (idx < out_log.size()) check(name, out_log[idx], e);
    else fail_bound(name);
  endtask

  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      m_if.tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every output transfer and on every statistics pulse.
  initial begin
    bit    stalled = 1'b0;
    beat_t held;
    beat_t got;
    forever begin
      @(negedge aclk);
      if (areset) begin
        stalled = 1'b0;
      end else begin
        got = {m_if.tdata, m_if.tlast, m_if.tuser};
        if (stalled) begin
          check("stall_valid_held", m_if.tvalid, 1);
          check("stall_beat_stable", got, held);
        end
        stalled = m_if.tvalid && !m_if.tready;
        held    = got;
        if (m_if.tvalid && m_if.tready) begin
          if (exp_q.size() == 0) fail_bound($sformatf("unexpected_beat%0d", out_log.size()));
          else check($sformatf("beat%0d", out_log.size()), got, exp_q.pop_front());
          out_log.push_back(m_if.tdata);
        end
        if (frame_stat_valid) begin
          stat_log.push_back(int'(frame_inside_count));
          if (stat_q.size() == 0) fail_bound("unexpected_stat");
          else check($sformatf("frame_stat%0d", stat_log.size() - 1), frame_inside_count, stat_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int base;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0; s_if.tuser = 1'b0;
    model_reset();
    repeat (3) @(posedge aclk);
    #1;
    check("rst_m_tvalid", m_if.tvalid, 0);
    check("rst_m_tdata", m_if.tdata, 0);
    check("rst_cfg_pending", cfg_pending, 0);
    check("rst_line_err", line_err, 0);
    check("rst_frame_count", frame_inside_count, 0);
    check("rst_stat_valid", frame_stat_valid, 0);
    areset = 1'b0;
    @(posedge aclk); #1;

    // Rectangle (10,10)-(19,19) in zero-outside mode.
    cfg_write(0, 10, 10);
    cfg_write(1, 10, 19);
    cfg_write(2, 19, 19);
    cfg_write(3, 19, 10);
    do_commit(1, '0);
    check("pending_after_commit", cfg_pending, 1);
    send_frame(-1, 0, 1'b1);

    rand_rdy = 1'b1;
    send_frame(-1, 0, 1'b0);
    send_frame(-1, 1, 1'b0);
    rand_rdy = 1'b0;
    wait_drain();

    check("pending_before_sof", cfg_pending, 1);
    send_frame(-1, 2, 1'b1);
    send_frame(-1, 0, 1'b0);
    wait_drain();

    chk_px("rect_inside_15_15", 0, 15, 15, 24'h800F0F);
    chk_px("rect_left_9_15", 0, 9, 15, 24'h000000);
    chk_px("rect_right_20_15", 0, 20, 15, 24'h000000);
    chk_px("tri_inside_5_20", 3, 5, 20, 24'h801405);
    chk_px("tri_fill_30_2", 3, 30, 2, 24'hFF00FF);
    chk_px("tri_vertex_0_0", 3, 0, 0, 24'h800000);
    chk_px("tri_vertex_31_23", 3, 31, 23, 24'h80171F);
    chk_px("zin_vertex_0_0", 4, 0, 0, 24'h000000);
    chk_px("zin_vertex_31_23", 4, 31, 23, 24'h000000);
    chk_px("zin_outside_30_2", 4, 30, 2, 24'h80021E);
    chk_px("zin_inside_5_20", 4, 5, 20, 24'h000000);
    if (stat_log.size() >= 4) begin
      check("stat_first_sof", stat_log[0], 0);
      check("stat_rect_a", stat_log[1], 100);
      check("stat_rect_b", stat_log[2], 100);
      check("stat_rect_c", stat_log[3], 100);
    end else begin
      fail_bound("stat_log_rect");
    end

    check("line_err_clean", line_err, 0);
    send_frame(3, 0, 1'b0);
    wait_drain();
    check("line_err_short_line", line_err, 1);
    do_commit(2, 24'hFF00FF);
    check("line_err_cleared_by_commit", line_err, 0);

    // Reset with beats in flight, then re-sync on the next start of frame.
    for (int k = 0; k < 40; k++) send_beat(k % W, k / W, (k % W) == W - 1, k == 0, 1'b1);
    check("pipe_busy_before_reset", m_if.tvalid, 1);
    areset = 1'b1;
    s_if.tvalid = 1'b0;
    #1;
    check("reset_drops_valid", m_if.tvalid, 0);
    exp_q.delete();
    stat_q.delete();
    model_reset();
    base = stat_log.size();
    @(posedge aclk); #1;
    areset = 1'b0;
    check("post_rst_pending", cfg_pending, 0);
    check("post_rst_line_err", line_err, 0);
    check("post_rst_count", frame_inside_count, 0);
    for (int k = 0; k < 5; k++) send_beat(k + 3, 7, 1'b0, 1'b0, 1'b0);
    s_if.tvalid = 1'b0;
    send_frame(-1, 0, 1'b0);
    send_beat(0, 0, 1'b0, 1'b1, 1'b1);
    s_if.tvalid = 1'b0;
    wait_drain();
    if (stat_log.size() >= base + 2) begin
      check("stat_after_reset_sof", stat_log[base], 0);
      check("stat_degenerate_all_inside", stat_log[base + 1], 768);
    end else begin
      fail_bound("stat_log_reset");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/roi_polygon_mask_stream.md
Name: roi_polygon_mask_stream

Overview:
AXI4-Stream video ROI masker, successor to the fixed-quad ROI stage. It accepts a run-time programmable convex polygon of NUM_VERTS vertices, a selectable mask mode and a fill colour, all double-buffered and applied on frame boundaries. Pixel data width is parametrised, and the datapath is a 3-stage pipeline with full backpressure. It also reports a per-frame inside-pixel count and a line-length error flag. It sits between the video source and downstream lane-detection stages.

Parameters:
DATA_W, 24, pixel width in bits
IMAGE_WIDTH, 640, pixels per line
IMAGE_HEIGHT, 480, lines per frame
NUM_VERTS, 4, polygon vertex count, legal range 3..8
COORD_W, 12, unsigned vertex/coordinate width; must satisfy 2^COORD_W > max(IMAGE_WIDTH, IMAGE_HEIGHT)

Ports:
aclk  in  1  clock
areset  in  1  reset, asynchronous, active-high
s_axis_tdata  in  DATA_W  input pixel
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
s_axis_tlast  in  1  end of line
s_axis_tuser  in  1  start of frame
m_axis_tdata  out  DATA_W  output pixel
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
m_axis_tlast  out  1  end of line, delayed
m_axis_tuser  out  1  start of frame, delayed
cfg_wr  in  1  write shadow vertex
cfg_idx  in  3  vertex index; writes with cfg_idx >= NUM_VERTS are ignored
cfg_x  in  COORD_W  vertex x
cfg_y  in  COORD_W  vertex y
cfg_mode  in  2  mode shadow, captured on cfg_commit
cfg_fill  in  DATA_W  fill colour shadow, captured on cfg_commit
cfg_commit  in  1  arm shadow set for the next frame start
cfg_pending  out  1  commit armed, not yet applied
frame_inside_count  out  clog2(IMAGE_WIDTH*IMAGE_HEIGHT+1)  inside pixels of the last completed frame
frame_stat_valid  out  1  one-cycle pulse when frame_inside_count updates
line_err  out  1  sticky line-length error

Behaviour:
- Reset (async assert, release synchronous to aclk):
  - All outputs are 0; pipeline valids are 0.
  - Counters, shadow and active vertex registers, mode and fill are all 0. Mode 0 is pass-through.
- Handshake:
  - ce = m_axis_tready | ~m_axis_tvalid; s_axis_tready = ce. This path is combinational from m_axis_tready.
  - Stages S0 (capture), S1 (deltas), S2 (products/compare and output register) advance only when ce = 1.
  - Each stage holds a valid bit; bubbles propagate.
  - Latency is 3 cycles from input acceptance to m_axis_tvalid when unstalled. No beat is ever dropped or duplicated.
- Coordinates:
  - An accepted beat with tuser = 1 is pixel (0,0), and x = 1 for the next beat.
  - Otherwise, an accepted beat with tlast = 1 sets x = 0 and y = y+1. y saturates at IMAGE_HEIGHT-1.
  - Otherwise x = x+1, saturating at IMAGE_WIDTH-1.
- line_err sets if tlast is accepted with x != IMAGE_WIDTH-1, or a beat is accepted at x = IMAGE_WIDTH-1 without tlast. It clears only on reset or cfg_commit.
- Inside test, edge i runs from Vi to Vi+1 mod NUM_VERTS:
  - side_i = (Xn-Xi)(y-Yi) - (Yn-Yi)(x-Xi).
  - Operands are signed COORD_W+1 bits; products and sum are signed 2*COORD_W+3 bits, with no truncation.
  - inside = all side_i <= 0. Boundary pixels count as inside.
  - Vertices are listed counter-clockwise in screen coordinates; non-convex input gives undefined masking but must not hang.
- Modes:
  - 0: pass tdata.
  - 1: zero pixels outside.
  - 2: zero pixels inside.
  - 3: replace outside pixels with the fill colour.
  - tlast and tuser are always passed through unchanged.
- Configuration:
  - cfg_wr updates the shadow vertex immediately.
  - cfg_commit sets cfg_pending and captures mode and fill into shadow.
  - When a tuser beat is accepted into S0 with cfg_pending = 1, the active set is loaded from shadow and cfg_pending clears.
  - All vertex-dependent terms are registered in S1, so the tuser pixel uses the new set and older in-flight pixels use the old set.
  - Simultaneous cfg_wr and tuser acceptance: the write lands in shadow only.
  - Simultaneous cfg_commit and tuser acceptance: the commit applies to the following frame, and cfg_pending stays 1.
- Statistics:
  - An accumulator counts output beats classified inside. Classification is mode-independent.
  - When an output beat with tuser is transferred, frame_inside_count is loaded with the accumulator, frame_stat_valid pulses, and the accumulator restarts from that beat's inside bit.
  - The first tuser after reset also pulses, with count 0.
- Reset mid-frame: everything clears. Data is discarded until the next tuser is accepted, with coordinates counted from 0 as if a frame had just started.

Test Plan:
- Mode 1 with rectangle (100,100),(100,199),(199,199),(199,100), a 640x480 ramp frame, ready held at 1 -> pixel (150,150) passes; (99,150) and (200,150) are 0. The next tuser gives frame_inside_count = 10000 and a frame_stat_valid pulse.
- Random m_axis_tready (50%) over 2 frames -> output sequence is identical to the ready=1 run, beat for beat, including tlast/tuser positions. No valid drop while stalled; data stable while stalled.
- Mid-frame, write a new triangle (0,0),(0,479),(639,479) in mode 3 with fill 0xFF00FF and commit -> the current frame is unchanged. At the next frame, (10,400) passes and (600,10) = 0xFF00FF. cfg_pending goes 1 then 0 exactly at the tuser acceptance.
- Pixel on the edge of the triangle, x = y·639/479 integer points (e.g. (0,0),(639,479)) -> treated as inside. Mode 2 zeroes them.
- Line of 639 pixels with early tlast -> line_err = 1 and y still advances. cfg_commit clears line_err.
- Assert areset for 1 cycle mid-frame with data in the pipeline -> m_axis_tvalid = 0 immediately. The next frame with tuser processes correctly with pass-through mode.
